// File: rtl/param_commit_ctrl.sv
// Commit controller: arbitrates two register-write requesters into shadow registers and
// applies them atomically on oscillator phase wrap or timeout. Optional macro: VOLUME_RAMP_EN.
module param_commit_ctrl #(
  parameter int              TO_W           = 16,
  parameter logic [TO_W-1:0] COMMIT_TIMEOUT = TO_W'(4096),
  parameter int              RAMP_DIV       = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_addr,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_addr,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        phase_wrap,
  output logic [7:0]  ctrl_out,
  output logic [23:0] freq_out,
  output logic [7:0]  duty_out,
  output logic [7:0]  volume_out,
  output logic        update_pending,
  output logic        apply_pulse
);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_FREQ0  = 8'h02;
  localparam logic [7:0] ADDR_FREQ1  = 8'h03;
  localparam logic [7:0] ADDR_FREQ2  = 8'h04;
  localparam logic [7:0] ADDR_DUTY   = 8'h05;
  localparam logic [7:0] ADDR_VOLUME = 8'h06;
  localparam logic [7:0] ADDR_COMMIT = 8'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            rr_ptr;
  logic            sel1;
  logic            xfer;
  logic [7:0]      wr_addr;
  logic [7:0]      wr_data;
  logic            arm;
  logic [TO_W-1:0] to_cnt;
  logic [23:0]     freq_sh;
  logic [7:0]      duty_sh;
  logic [7:0]      vol_sh;

  // Round-robin grant; the whole write port is closed while live registers are being loaded
  always_comb begin
    sel1       = 1'b0;
    if (req1_valid && (!req0_valid || rr_ptr))
      sel1 = 1'b1;
    req0_ready = (state != APPLY) && req0_valid && !sel1;
    req1_ready = (state != APPLY) && req1_valid && sel1;
    xfer       = req0_ready || req1_ready;
    wr_addr    = sel1 ? req1_addr : req0_addr;
    wr_data    = sel1 ? req1_data : req0_data;
    arm        = xfer && ((wr_addr == ADDR_FREQ2) || (wr_addr == ADDR_COMMIT));
  end

  // Pointer moves to the side that was not just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (xfer)
      rr_ptr <= ~sel1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (arm)
          state_next = (COMMIT_TIMEOUT == '0) ? APPLY : ARMED;
      end
      ARMED: begin
        if (phase_wrap || (to_cnt == '0))
          state_next = APPLY;
      end
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    update_pending = (state == ARMED) || (state == APPLY);
    apply_pulse    = (state == APPLY);
  end

  // Re-arming while already armed must not extend the deadline
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if ((state == IDLE) && arm)
      to_cnt <= COMMIT_TIMEOUT;
    else if ((state == ARMED) && (to_cnt != '0))
      to_cnt <= to_cnt - TO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_out <= 8'h1C;
      freq_sh  <= 24'h000000;
      duty_sh  <= 8'h80;
      vol_sh   <= 8'hFF;
    end else if (xfer) begin
      case (wr_addr)
        ADDR_CTRL:   ctrl_out      <= wr_data;
        ADDR_FREQ0:  freq_sh[7:0]  <= wr_data;
        ADDR_FREQ1:  freq_sh[15:8] <= wr_data;
        ADDR_FREQ2:  freq_sh[23:16] <= wr_data;
        ADDR_DUTY:   duty_sh       <= wr_data;
        ADDR_VOLUME: vol_sh        <= wr_data;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_out <= 24'h000000;
      duty_out <= 8'h80;
    end else if (state == APPLY) begin
      freq_out <= freq_sh;
      duty_out <= duty_sh;
    end
  end

`ifdef VOLUME_RAMP_EN
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PW-1:0] pre_cnt;
  logic          pre_wrap;
  logic [7:0]    vol_target;

  assign pre_wrap = (pre_cnt == PW'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre_cnt <= '0;
    else if (pre_wrap)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + PW'(1);
  end

  // Volume walks one step per prescaler period so a commit never produces a zipper click
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vol_target <= 8'hFF;
      volume_out <= 8'hFF;
    end else begin
      if (state == APPLY)
        vol_target <= vol_sh;
      if (pre_wrap) begin
        if (volume_out < vol_target)
          volume_out <= volume_out + 8'd1;
        else if (volume_out > vol_target)
          volume_out <= volume_out - 8'd1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      volume_out <= 8'hFF;
    else if (state == APPLY)
      volume_out <= vol_sh;
  end
`endif

endmodule

// File: tb/tb_param_commit_ctrl.sv
// Randomized self-checking bench for param_commit_ctrl against a register-map level model.
// Build with VOLUME_RAMP_EN defined to also exercise the volume ramp.
module tb_param_commit_ctrl;

  localparam logic [15:0] TO   = 16'd16;
  localparam int          RDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_addr = 8'h00, req0_data = 8'h00;
  logic [7:0]  req1_addr = 8'h00, req1_data = 8'h00;
  logic        req0_ready, req1_ready;
  logic        phase_wrap = 1'b0;
  logic [7:0]  ctrl_out, duty_out, volume_out;
  logic [23:0] freq_out;
  logic        update_pending, apply_pulse;

  int checks = 0;
  int fails  = 0;

  // Register-map model
  logic [7:0]  m_ctrl, m_duty, m_vol, m_duty_sh, m_vol_sh;
  logic [23:0] m_freq, m_freq_sh;
  int          m_ptr;

  always #5 clk = ~clk;

  param_commit_ctrl #(.TO_W(16), .COMMIT_TIMEOUT(TO), .RAMP_DIV(RDIV)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .phase_wrap(phase_wrap),
    .ctrl_out(ctrl_out), .freq_out(freq_out), .duty_out(duty_out), .volume_out(volume_out),
    .update_pending(update_pending), .apply_pulse(apply_pulse)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_ctrl = 8'h1C; m_freq = 24'h0; m_freq_sh = 24'h0;
    m_duty = 8'h80; m_duty_sh = 8'h80; m_vol = 8'hFF; m_vol_sh = 8'hFF;
    m_ptr = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'h00: m_ctrl = d;
      8'h02: m_freq_sh = {m_freq_sh[23:8], d};
      8'h03: m_freq_sh = {m_freq_sh[23:16], d, m_freq_sh[7:0]};
      8'h04: m_freq_sh = {d, m_freq_sh[15:0]};
      8'h05: m_duty_sh = d;
      8'h06: m_vol_sh = d;
      default: ;
    endcase
  endtask

  task automatic model_commit;
    m_freq = m_freq_sh; m_duty = m_duty_sh; m_vol = m_vol_sh;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; phase_wrap = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    model_reset;
  endtask

  // Single write through one requester; returns one step after the accepting edge
  task automatic do_write(input int port, input logic [7:0] a, input logic [7:0] d);
    bit done = 0;
    int n = 0;
    if (port == 0) begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    else           begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    while (!done && n < 40) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) done = 1;
      tick;
      n++;
    end
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    checks++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL write_accept: port %0d addr %h not accepted after %0d cycles, required within 40", port, a, n);
    end else begin
      model_write(a, d);
      m_ptr = (port == 0) ? 1 : 0;
    end
  endtask

  // Arm through 0x07 and wrap immediately; returns in the cycle after APPLY
  task automatic commit_now(input int port);
    do_write(port, 8'h07, 8'($urandom));
    phase_wrap = 1'b1;
    tick;
    phase_wrap = 1'b0;
    tick;
    model_commit;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (ctrl_out !== 8'h1C) begin fails++; $display("[TB] FAIL reset_ctrl: got %h expected 1c", ctrl_out); end
    checks++; if (freq_out !== 24'h0) begin fails++; $display("[TB] FAIL reset_freq: got %h expected 000000", freq_out); end
    checks++; if (duty_out !== 8'h80) begin fails++; $display("[TB] FAIL reset_duty: got %h expected 80", duty_out); end
    checks++; if (volume_out !== 8'hFF) begin fails++; $display("[TB] FAIL reset_volume: got %h expected ff", volume_out); end
    checks++; if (update_pending !== 1'b0) begin fails++; $display("[TB] FAIL reset_pending: got %b expected 0", update_pending); end
    checks++; if (apply_pulse !== 1'b0) begin fails++; $display("[TB] FAIL reset_apply: got %b expected 0", apply_pulse); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_ctrl_direct;
    do_write(0, 8'h00, 8'h03);
    checks++; if (ctrl_out !== 8'h03) begin fails++; $display("[TB] FAIL ctrl_direct: got %h expected 03", ctrl_out); end
    checks++; if (update_pending !== 1'b0) begin fails++; $display("[TB] FAIL ctrl_no_pending: got %b expected 0", update_pending); end
  endtask

  task automatic test_timeout_commit;
    int k;
    do_write(0, 8'h02, 8'h34);
    do_write(0, 8'h03, 8'h12);
    do_write(0, 8'h04, 8'h00);
    for (int i = 0; i < 16; i++) begin
      checks++; if (freq_out !== m_freq || apply_pulse !== 1'b0 || update_pending !== 1'b1) begin
        fails++; $display("[TB] FAIL armed_hold: cycle %0d freq %h apply %b pending %b, expected freq %h apply 0 pending 1", i, freq_out, apply_pulse, update_pending, m_freq);
      end
      tick;
    end
    k = 0;
    while (apply_pulse !== 1'b1 && k < 8) begin tick; k++; end
    checks++; if (apply_pulse !== 1'b1) begin fails++; $display("[TB] FAIL timeout_apply: apply_pulse %b, expected 1 within 8 cycles of timeout", apply_pulse); end
    tick;
    model_commit;
    checks++; if (apply_pulse !== 1'b0) begin fails++; $display("[TB] FAIL timeout_single_pulse: got %b expected 0", apply_pulse); end
    checks++; if (freq_out !== 24'h001234) begin fails++; $display("[TB] FAIL timeout_freq: got %h expected 001234", freq_out); end
    checks++; if (update_pending !== 1'b0) begin fails++; $display("[TB] FAIL timeout_pending: got %b expected 0", update_pending); end
  endtask

  task automatic test_phase_wrap;
    do_write(1, 8'h05, 8'h40);
`ifndef VOLUME_RAMP_EN
    do_write(1, 8'h06, 8'h90);
`endif
    do_write(0, 8'h07, 8'hA5);
    tick;
    phase_wrap = 1'b1;
    tick;
    phase_wrap = 1'b0;
    checks++; if (apply_pulse !== 1'b1 || duty_out !== m_duty) begin
      fails++; $display("[TB] FAIL wrap_apply: apply %b duty %h, expected apply 1 duty %h", apply_pulse, duty_out, m_duty);
    end
    tick;
    model_commit;
    checks++; if (apply_pulse !== 1'b0 || update_pending !== 1'b0) begin
      fails++; $display("[TB] FAIL wrap_done: apply %b pending %b, expected 0 0", apply_pulse, update_pending);
    end
    checks++; if (duty_out !== 8'h40) begin fails++; $display("[TB] FAIL wrap_duty: got %h expected 40", duty_out); end
    checks++; if (volume_out !== m_vol) begin fails++; $display("[TB] FAIL wrap_volume: got %h expected %h", volume_out, m_vol); end
    checks++; if (freq_out !== m_freq) begin fails++; $display("[TB] FAIL wrap_freq: got %h expected %h", freq_out, m_freq); end
  endtask

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;

  task automatic test_back_to_back;
    wr_t q0[$];
    wr_t q1[$];
    bit  e0, e1;
    int  n = 0;
    q0 = '{'{8'h02, 8'hA1}, '{8'h03, 8'hB2}, '{8'h04, 8'hC3}, '{8'h05, 8'hD4}};
    q1 = '{'{8'h01, 8'h11}, '{8'h05, 8'h22}, '{8'h07, 8'h00}, '{8'h02, 8'h33}};
    while ((q0.size() > 0 || q1.size() > 0) && n < 40) begin
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      if (q0.size() > 0) begin req0_addr = q0[0].a; req0_data = q0[0].d; end
      if (q1.size() > 0) begin req1_addr = q1[0].a; req1_data = q1[0].d; end
      e0 = req0_valid && (!req1_valid || m_ptr == 0);
      e1 = req1_valid && (!req0_valid || m_ptr == 1);
      @(negedge clk);
      checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
        fails++; $display("[TB] FAIL rr_grant: step %0d readys %b%b, expected %b%b", n, req0_ready, req1_ready, e0, e1);
      end
      tick;
      if (e0) begin model_write(q0[0].a, q0[0].d); void'(q0.pop_front()); m_ptr = 1; end
      else if (e1) begin model_write(q1[0].a, q1[0].d); void'(q1.pop_front()); m_ptr = 0; end
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    phase_wrap = 1'b1;
    tick;
    phase_wrap = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'h01;
    req1_valid = 1'b1; req1_addr = 8'h01;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready, apply_pulse} !== 3'b001) begin
      fails++; $display("[TB] FAIL apply_blocks: ready0 %b ready1 %b apply %b, expected 0 0 1", req0_ready, req1_ready, apply_pulse);
    end
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_commit;
    checks++; if (freq_out !== m_freq || duty_out !== m_duty) begin
      fails++; $display("[TB] FAIL rr_commit: freq %h duty %h, expected %h %h", freq_out, duty_out, m_freq, m_duty);
    end
  endtask

  task automatic test_random;
    logic [7:0] a;
    int port;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 6; w++) begin
        port = int'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0: a = 8'h00;
          1: a = 8'h02;
          2: a = 8'h03;
          3: a = 8'h05;
`ifdef VOLUME_RAMP_EN
          4: a = 8'h01;
`else
          4: a = 8'h06;
`endif
          default: a = 8'($urandom_range(8, 255));
        endcase
        do_write(port, a, 8'($urandom));
        checks++; if (ctrl_out !== m_ctrl || freq_out !== m_freq || duty_out !== m_duty || update_pending !== 1'b0) begin
          fails++; $display("[TB] FAIL rand_write: addr %h ctrl %h freq %h duty %h pend %b, expected %h %h %h 0", a, ctrl_out, freq_out, duty_out, update_pending, m_ctrl, m_freq, m_duty);
        end
      end
      commit_now(int'($urandom_range(0, 1)));
      checks++; if (freq_out !== m_freq || duty_out !== m_duty || volume_out !== m_vol) begin
        fails++; $display("[TB] FAIL rand_commit: freq %h duty %h vol %h, expected %h %h %h", freq_out, duty_out, volume_out, m_freq, m_duty, m_vol);
      end
    end
  endtask

  task automatic test_reset_mid_armed;
    do_write(0, 8'h04, 8'h55);
    checks++; if (update_pending !== 1'b1) begin fails++; $display("[TB] FAIL mid_armed_pending: got %b expected 1", update_pending); end
    do_reset;
    checks++; if (freq_out !== 24'h0 || update_pending !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_armed_reset: freq %h pend %b, expected 000000 0", freq_out, update_pending);
    end
    phase_wrap = 1'b1;
    do_write(0, 8'h07, 8'h00);
    phase_wrap = 1'b0;
    checks++; if (update_pending !== 1'b1 || apply_pulse !== 1'b0) begin
      fails++; $display("[TB] FAIL arm_wrap_same_cycle: pend %b apply %b, expected 1 0", update_pending, apply_pulse);
    end
    tick;
    checks++; if (apply_pulse !== 1'b0) begin fails++; $display("[TB] FAIL arm_wrap_not_held: apply %b expected 0", apply_pulse); end
    phase_wrap = 1'b1;
    tick;
    phase_wrap = 1'b0;
    tick;
    model_commit;
    checks++; if (freq_out !== m_freq) begin fails++; $display("[TB] FAIL shadow_discarded: freq %h expected %h", freq_out, m_freq); end
  endtask

`ifdef VOLUME_RAMP_EN
  task automatic test_volume_ramp;
    logic [7:0] prev;
    int changes = 0;
    int last_t = 0;
    do_write(0, 8'h06, 8'hFC);
    commit_now(0);
    prev = volume_out;
    checks++; if (prev !== 8'hFF) begin fails++; $display("[TB] FAIL ramp_start: got %h expected ff", prev); end
    for (int t = 0; t < 24; t++) begin
      tick;
      if (volume_out !== prev) begin
        changes++;
        checks++; if (volume_out !== 8'(8'hFF - changes)) begin
          fails++; $display("[TB] FAIL ramp_step: got %h expected %h", volume_out, 8'(8'hFF - changes));
        end
        if (changes > 1) begin
          checks++; if (t - last_t != RDIV) begin fails++; $display("[TB] FAIL ramp_spacing: got %0d cycles expected %0d", t - last_t, RDIV); end
        end
        last_t = t;
        prev = volume_out;
      end
    end
    checks++; if (volume_out !== 8'hFC || changes != 3) begin
      fails++; $display("[TB] FAIL ramp_final: vol %h steps %0d, expected fc 3", volume_out, changes);
    end
  endtask
`endif

  initial begin
    model_reset;
    test_reset;
    test_ctrl_direct;
    test_timeout_commit;
    test_phase_wrap;
    test_back_to_back;
    test_random;
    test_reset_mid_armed;
`ifdef VOLUME_RAMP_EN
    test_volume_ramp;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
